fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that owns the architectural fetch PC and consumes the execute stage's resolved next-PC. Predicts sequential flow (PC+4), issues one instruction-memory request at a time, and hands fetched instructions to decode through a valid/ready register. When execute reports a next-PC that differs from the sequential prediction, it redirects, flushing the in-flight or buffered instruction.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ex_valid  in  1  execute resolved one instruction this cycle.
- ex_pc  in  32  PC of that instruction.
- ex_pc_next  in  32  resolved next PC of that instruction.
- imem_req_valid  out  1  fetch request pending.
- imem_req_ready  in  1  memory accepts request; handshake = valid && ready.
- imem_addr  out  32  request address, word aligned.
- imem_resp_valid  in  1  response data valid; exactly one per accepted request, earliest the cycle after acceptance.
- imem_resp_data  in  32  instruction word.
- if_valid  out  1  fetched instruction available to decode.
- if_ready  in  1  decode consumes; transfer = if_valid && if_ready.
- if_pc  out  32  address of if_instr.
- if_instr  out  32  instruction word.
- fetch_pc  out  32  address of next request to be issued.
- fetch_fault  out  1  misaligned redirect target; held until cleared.

## Operation
- redirect = ex_valid && (ex_pc_next != ex_pc + 32'd4); 32-bit adds, wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0, no fault).
- States: S_IDLE, S_REQ, S_WAIT, S_OUT, S_FAULT.
- S_IDLE: entered only from reset; next cycle -> S_REQ.
- S_REQ: imem_req_valid=1, imem_addr=fetch_pc. On handshake: latch req_pc=fetch_pc, fetch_pc += 4, -> S_WAIT.
- S_WAIT: on imem_resp_valid: if discard set, drop data, clear discard, -> S_REQ; else load if_pc=req_pc, if_instr=data, if_valid=1, -> S_OUT.
- S_OUT: on transfer: if_valid=0, -> S_REQ.
- Redirect has priority over every other event in the same cycle:
  - fetch_pc <= ex_pc_next; if_valid <= 0 (buffered instruction dropped, even if if_ready=1 that cycle).
  - In S_REQ with simultaneous handshake: request counts as issued, set discard, -> S_WAIT.
  - In S_REQ without handshake: stay S_REQ; new address presented next cycle (memory only samples at handshake).
  - In S_WAIT: set discard (response same cycle is dropped, -> S_REQ; otherwise stay S_WAIT).
  - In S_OUT: -> S_REQ.
- Misaligned target (ex_pc_next[1:0] != 0): redirect handled as above, but destination is S_FAULT instead of S_REQ (S_WAIT with discard still drains first, then S_FAULT); fetch_fault=1. S_FAULT issues nothing; leaves only on an aligned redirect (-> S_REQ, fetch_fault=0) or reset.
- ex_valid with ex_pc_next == ex_pc+4: no effect.

## Timing
- Reset (rst_n=0 at edge): state=S_IDLE, fetch_pc=RESET_VECTOR, imem_req_valid=0, imem_addr=RESET_VECTOR, if_valid=0, if_pc=0, if_instr=0, fetch_fault=0, discard=0. Reset mid-transaction abandons outstanding response; a stale imem_resp_valid arriving in S_IDLE/S_REQ is ignored.
- First request: imem_req_valid=1 two cycles after rst_n rises at an edge (IDLE then REQ).
- Response-to-decode: if_valid rises the cycle after imem_resp_valid.
- Redirect-to-request: imem_addr=ex_pc_next the cycle after redirect.
- Throughput: at most one instruction per 3 cycles with zero-wait memory and if_ready=1; one request outstanding max.
- All outputs registered except imem_req_valid/imem_addr (decoded from state and fetch_pc registers, no input-to-output paths).

## Structure
- Shared package fetch_pkg: state enum type, INSTR_WIDTH=32, PC_STEP=32'd4.
- Sub-module pc_gen: combinational redirect/misalign detection and fetch_pc next-value mux; FSM and output register in fetch_unit.

## Test plan
- Reset, zero-wait memory, if_ready=1 -> requests at 0x0, 0x4, 0x8; if_pc/if_instr match in order, 3-cycle spacing.
- ex_valid, ex_pc=0x4, ex_pc_next=0x100 during S_WAIT -> returned word dropped, next imem_addr=0x100, no if_valid for the stale word.
- Redirect to 0x200 while if_valid=1 and if_ready=1 same cycle -> no transfer counted, if_valid=0, next request 0x200.
- if_ready=0 for 5 cycles in S_OUT -> if_valid, if_pc, if_instr stable, no new request issued.
- ex_pc_next=0x102 -> fetch_fault=1, no requests; then ex_pc_next=0x104 (ex_pc=0x0) -> fetch_fault=0, request 0x104.
- Redirect to 0xFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000, no fault.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned INSTR_WIDTH = 32;
    localparam logic [31:0] PC_STEP     = 32'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_FAULT
    } fetch_state_e;

endpackage

// File: rtl/pc_gen.sv
// Redirect and misalignment detection plus the fetch PC next-value mux.
module pc_gen
    import fetch_pkg::*;
(
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_pc_next,
    input  logic [31:0] fetch_pc,
    input  logic        advance,
    output logic        redirect,
    output logic        misaligned,
    output logic [31:0] fetch_pc_next
);

    always_comb begin
        // Sequential prediction only; any other resolved target is a redirect.
        redirect   = ex_valid && (ex_pc_next != (ex_pc + PC_STEP));
        misaligned = redirect && (ex_pc_next[1:0] != 2'b00);

        if (redirect) begin
            fetch_pc_next = ex_pc_next;
        end else if (advance) begin
            fetch_pc_next = fetch_pc + PC_STEP;
        end else begin
            fetch_pc_next = fetch_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, PC+4 prediction,
// redirect from execute, and a valid/ready output register toward decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ex_valid,
    input  logic [31:0]            ex_pc,
    input  logic [31:0]            ex_pc_next,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [31:0]            imem_addr,
    input  logic                   imem_resp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_resp_data,
    output logic                   if_valid,
    input  logic                   if_ready,
    output logic [31:0]            if_pc,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic [31:0]            fetch_pc,
    output logic                   fetch_fault
);

    fetch_state_e           state_q, state_d;
    logic [31:0]            fetch_pc_q, fetch_pc_d;
    logic [31:0]            req_pc_q, req_pc_d;
    logic                   discard_q, discard_d;
    logic                   fault_q, fault_d;
    logic                   if_valid_q, if_valid_d;
    logic [31:0]            if_pc_q, if_pc_d;
    logic [INSTR_WIDTH-1:0] if_instr_q, if_instr_d;

    logic         redirect;
    logic         misaligned;
    logic         handshake;
    fetch_state_e resume_state;

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_addr      = fetch_pc_q;
    assign handshake      = imem_req_valid && imem_req_ready;

    pc_gen u_pc_gen (
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_pc_next    (ex_pc_next),
        .fetch_pc      (fetch_pc_q),
        .advance       (handshake),
        .redirect      (redirect),
        .misaligned    (misaligned),
        .fetch_pc_next (fetch_pc_d)
    );

    always_comb begin
        state_d    = state_q;
        req_pc_d   = req_pc_q;
        discard_d  = discard_q;
        fault_d    = fault_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;

        if (redirect) begin
            fault_d = misaligned;
        end
        // Where to go once nothing is in flight: a pending fault parks the stage.
        resume_state = fault_d ? S_FAULT : S_REQ;

        unique case (state_q)
            S_IDLE: begin
                state_d = resume_state;
            end
            S_REQ: begin
                if (handshake) begin
                    req_pc_d = fetch_pc_q;
                    state_d  = S_WAIT;
                    if (redirect) begin
                        discard_d = 1'b1;
                    end
                end else if (redirect) begin
                    state_d = resume_state;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (discard_q || redirect) begin
                        discard_d = 1'b0;
                        state_d   = resume_state;
                    end else begin
                        if_valid_d = 1'b1;
                        if_pc_d    = req_pc_q;
                        if_instr_d = imem_resp_data;
                        state_d    = S_OUT;
                    end
                end else if (redirect) begin
                    discard_d = 1'b1;
                end
            end
            S_OUT: begin
                if (redirect) begin
                    state_d = resume_state;
                end else if (if_ready) begin
                    if_valid_d = 1'b0;
                    state_d    = S_REQ;
                end
            end
            S_FAULT: begin
                if (redirect) begin
                    state_d = resume_state;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A redirect kills the buffered instruction even if decode is ready.
        if (redirect) begin
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_VECTOR;
            req_pc_q   <= 32'd0;
            discard_q  <= 1'b0;
            fault_q    <= 1'b0;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'd0;
            if_instr_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            discard_q  <= discard_d;
            fault_q    <= fault_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    assign if_valid    = if_valid_q;
    assign if_pc       = if_pc_q;
    assign if_instr    = if_instr_q;
    assign fetch_pc    = fetch_pc_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model plus request/transfer scoreboards.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = 32'd0;
    logic [31:0] ex_pc_next = 32'd0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] fetch_pc;
    logic        fetch_fault;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int mem_lat = 0;

    logic [31:0] req_q[$];
    logic [63:0] out_q[$];
    int          xfer_cycles[$];

    fetch_unit #(
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_valid        (ex_valid),
        .ex_pc           (ex_pc),
        .ex_pc_next      (ex_pc_next),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .fetch_pc        (fetch_pc),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    // Memory: instruction word is the bitwise inverse of its address.
    always begin : mem_model
        logic [31:0] a;
        @(negedge clk);
        if (rst_n && imem_req_valid && imem_req_ready) begin
            a = imem_addr;
            @(posedge clk);
            repeat (mem_lat) @(posedge clk);
            #1;
            imem_resp_valid = 1'b1;
            imem_resp_data  = ~a;
            @(posedge clk);
            #1;
            imem_resp_valid = 1'b0;
        end
    end

    // Scoreboard: every request and every real transfer must match the next expectation.
    always @(negedge clk) begin : monitor
        logic [31:0] exp_addr;
        logic [63:0] exp_out;
        logic        tb_redirect;
        cycle++;
        tb_redirect = ex_valid && (ex_pc_next != ex_pc + 32'd4);
        if (rst_n) begin
            if (imem_req_valid && imem_req_ready) begin
                checks++;
                if (req_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_req: got addr=%h, required none", imem_addr);
                end else begin
                    exp_addr = req_q.pop_front();
                    if (imem_addr !== exp_addr) begin
                        failures++;
                        $display("FAIL req_addr: got %h, required %h", imem_addr, exp_addr);
                    end
                end
            end
            if (if_valid && if_ready && !tb_redirect) begin
                checks++;
                xfer_cycles.push_back(cycle);
                if (out_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_xfer: got pc=%h instr=%h, required none",
                             if_pc, if_instr);
                end else begin
                    exp_out = out_q.pop_front();
                    if ({if_pc, if_instr} !== exp_out) begin
                        failures++;
                        $display("FAIL xfer: got pc=%h instr=%h, required pc=%h instr=%h",
                                 if_pc, if_instr, exp_out[63:32], exp_out[31:0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        req_q.push_back(pc);
        out_q.push_back({pc, ~pc});
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        if_ready       = 1'b0;
        ex_valid       = 1'b0;
        mem_lat        = 0;
        repeat (3) tick();
        req_q.delete();
        out_q.delete();
        xfer_cycles.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (req_q.size() == 0 && out_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        imem_req_ready = 1'b0;
    endtask

    task automatic wait_if_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (if_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        if_ready = 1'b0;
        ex_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if ({imem_req_valid, imem_addr, if_valid, if_pc, if_instr, fetch_pc, fetch_fault} !==
            {1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: got req_valid=%b addr=%h if_valid=%b pc=%h instr=%h fpc=%h fault=%b, required all zero",
                     imem_req_valid, imem_addr, if_valid, if_pc, if_instr, fetch_pc, fetch_fault);
        end
        rst_n = 1'b1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req: got req_valid=%b, required 0", imem_req_valid);
        end
        tick();
        checks++;
        if ({imem_req_valid, imem_addr} !== {1'b1, 32'd0}) begin
            failures++;
            $display("FAIL first_req: got valid=%b addr=%h, required valid=1 addr=0",
                     imem_req_valid, imem_addr);
        end
    endtask

    task automatic test_sequential();
        bit ok;
        do_reset();
        expect_fetch(32'h0);
        expect_fetch(32'h4);
        expect_fetch(32'h8);
        // Resolved next-PC equal to the sequential prediction must be ignored.
        ex_valid = 1'b1;
        ex_pc = 32'h40;
        ex_pc_next = 32'h44;
        imem_req_ready = 1'b1;
        if_ready = 1'b1;
        wait_drain(60, ok);
        ex_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL seq_drain: got reqs_left=%0d outs_left=%0d, required 0/0",
                     req_q.size(), out_q.size());
        end
        checks++;
        if (xfer_cycles.size() != 3 || xfer_cycles[1] - xfer_cycles[0] != 3 ||
            xfer_cycles[2] - xfer_cycles[1] != 3) begin
            failures++;
            $display("FAIL seq_spacing: got %0d transfers, required 3 spaced by 3 cycles",
                     xfer_cycles.size());
        end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        do_reset();
        mem_lat = 2;
        imem_req_ready = 1'b1;
        if_ready = 1'b1;
        req_q.push_back(32'h0);
        for (int i = 0; i < 10 && req_q.size() != 0; i++) tick();
        expect_fetch(32'h100);
        ex_valid = 1'b1;
        ex_pc = 32'h4;
        ex_pc_next = 32'h100;
        tick();
        ex_valid = 1'b0;
        checks++;
        if ({fetch_pc, if_valid, imem_req_valid} !== {32'h100, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL wait_redirect: got fpc=%h if_valid=%b req_valid=%b, required 100/0/0",
                     fetch_pc, if_valid, imem_req_valid);
        end
        wait_drain(60, ok);
        mem_lat = 0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_drain: got reqs_left=%0d outs_left=%0d, required 0/0",
                     req_q.size(), out_q.size());
        end
    endtask

    task automatic test_redirect_handshake();
        bit ok;
        do_reset();
        imem_req_ready = 1'b1;
        if_ready = 1'b1;
        req_q.push_back(32'h0);
        tick();
        expect_fetch(32'h300);
        ex_valid = 1'b1;
        ex_pc = 32'h10;
        ex_pc_next = 32'h300;
        tick();
        ex_valid = 1'b0;
        checks++;
        if ({fetch_pc, imem_req_valid} !== {32'h300, 1'b0}) begin
            failures++;
            $display("FAIL hs_redirect: got fpc=%h req_valid=%b, required 300/0",
                     fetch_pc, imem_req_valid);
        end
        wait_drain(40, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL hs_drain: got reqs_left=%0d outs_left=%0d, required 0/0",
                     req_q.size(), out_q.size());
        end
    endtask

    task automatic test_redirect_out();
        bit ok;
        do_reset();
        imem_req_ready = 1'b1;
        req_q.push_back(32'h0);
        wait_if_valid(20, ok);
        checks++;
        if (!ok || if_pc !== 32'h0 || if_instr !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL out_load: got if_valid=%b pc=%h instr=%h, required 1/0/ffffffff",
                     if_valid, if_pc, if_instr);
        end
        expect_fetch(32'h200);
        if_ready = 1'b1;
        ex_valid = 1'b1;
        ex_pc = 32'h0;
        ex_pc_next = 32'h200;
        tick();
        ex_valid = 1'b0;
        checks++;
        if ({if_valid, imem_req_valid, imem_addr} !== {1'b0, 1'b1, 32'h200}) begin
            failures++;
            $display("FAIL out_redirect: got if_valid=%b req_valid=%b addr=%h, required 0/1/200",
                     if_valid, imem_req_valid, imem_addr);
        end
        wait_drain(40, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL out_drain: got reqs_left=%0d outs_left=%0d, required 0/0",
                     req_q.size(), out_q.size());
        end
    endtask

    task automatic test_stall();
        bit ok;
        do_reset();
        imem_req_ready = 1'b1;
        req_q.push_back(32'h0);
        wait_if_valid(20, ok);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({if_valid, if_pc, if_instr, imem_req_valid} !==
                {1'b1, 32'h0, 32'hFFFF_FFFF, 1'b0}) begin
                failures++;
                $display("FAIL stall_hold: got if_valid=%b pc=%h instr=%h req_valid=%b, required 1/0/ffffffff/0",
                         if_valid, if_pc, if_instr, imem_req_valid);
            end
        end
        out_q.push_back({32'h0, 32'hFFFF_FFFF});
        if_ready = 1'b1;
        wait_drain(10, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL stall_drain: got outs_left=%0d, required 0", out_q.size());
        end
    endtask

    task automatic test_fault();
        bit ok;
        do_reset();
        tick();
        ex_valid = 1'b1;
        ex_pc = 32'h0;
        ex_pc_next = 32'h102;
        tick();
        ex_valid = 1'b0;
        checks++;
        if ({fetch_fault, imem_req_valid, fetch_pc} !== {1'b1, 1'b0, 32'h102}) begin
            failures++;
            $display("FAIL fault_set: got fault=%b req_valid=%b fpc=%h, required 1/0/102",
                     fetch_fault, imem_req_valid, fetch_pc);
        end
        imem_req_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if ({fetch_fault, imem_req_valid} !== {1'b1, 1'b0}) begin
            failures++;
            $display("FAIL fault_hold: got fault=%b req_valid=%b, required 1/0",
                     fetch_fault, imem_req_valid);
        end
        expect_fetch(32'h104);
        if_ready = 1'b1;
        ex_valid = 1'b1;
        ex_pc = 32'h0;
        ex_pc_next = 32'h104;
        tick();
        ex_valid = 1'b0;
        checks++;
        if ({fetch_fault, imem_req_valid, imem_addr} !== {1'b0, 1'b1, 32'h104}) begin
            failures++;
            $display("FAIL fault_clear: got fault=%b req_valid=%b addr=%h, required 0/1/104",
                     fetch_fault, imem_req_valid, imem_addr);
        end
        wait_drain(40, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL fault_drain: got reqs_left=%0d outs_left=%0d, required 0/0",
                     req_q.size(), out_q.size());
        end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        tick();
        ex_valid = 1'b1;
        ex_pc = 32'h0;
        ex_pc_next = 32'hFFFF_FFFC;
        tick();
        ex_valid = 1'b0;
        expect_fetch(32'hFFFF_FFFC);
        expect_fetch(32'h0000_0000);
        imem_req_ready = 1'b1;
        if_ready = 1'b1;
        wait_drain(40, ok);
        checks++;
        if (!ok || fetch_fault !== 1'b0) begin
            failures++;
            $display("FAIL wrap: got reqs_left=%0d outs_left=%0d fault=%b, required 0/0/0",
                     req_q.size(), out_q.size(), fetch_fault);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect_wait();
        test_redirect_handshake();
        test_redirect_out();
        test_stall();
        test_fault();
        test_wrap();
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
